// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the split L1 caches, the pmem arbiter and physical memory.
// master: arbiter view; slave: environment (caches + memory) view.
interface pmem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);
  logic              icache_pmem_read;
  logic [ADDR_W-1:0] icache_pmem_addr;
  logic              icache_pmem_resp;
  logic [LINE_W-1:0] icache_pmem_rdata;

  logic              dcache_pmem_read;
  logic              dcache_pmem_write;
  logic [ADDR_W-1:0] dcache_pmem_addr;
  logic [LINE_W-1:0] dcache_pmem_wdata;
  logic              dcache_pmem_resp;
  logic [LINE_W-1:0] dcache_pmem_rdata;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  logic [1:0]        grant;

  modport master (
    input  icache_pmem_read, icache_pmem_addr,
    input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_addr, dcache_pmem_wdata,
    input  pmem_resp, pmem_rdata,
    output icache_pmem_resp, icache_pmem_rdata,
    output dcache_pmem_resp, dcache_pmem_rdata,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output grant
  );

  modport slave (
    output icache_pmem_read, icache_pmem_addr,
    output dcache_pmem_read, dcache_pmem_write, dcache_pmem_addr, dcache_pmem_wdata,
    output pmem_resp, pmem_rdata,
    input  icache_pmem_resp, icache_pmem_rdata,
    input  dcache_pmem_resp, dcache_pmem_rdata,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  grant
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache line misses; one transaction in
// flight. Define PMEM_ARB_ROUND_ROBIN_EN for round-robin ties, otherwise D-cache wins ties.
module pmem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  pmem_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy, StDone} state_e;
  typedef enum logic {GrantI, GrantD} owner_e;

  state_e state_q, state_d;
  owner_e last_grant_q, last_grant_d;

  logic i_req;
  logic d_req;

  assign i_req = bus.icache_pmem_read;
  assign d_req = bus.dcache_pmem_read | bus.dcache_pmem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    last_grant_d          = last_grant_q;
    bus.pmem_read         = 1'b0;
    bus.pmem_write        = 1'b0;
    bus.pmem_addr         = {ADDR_W{1'b0}};
    bus.pmem_wdata        = {LINE_W{1'b0}};
    bus.icache_pmem_resp  = 1'b0;
    bus.icache_pmem_rdata = {LINE_W{1'b0}};
    bus.dcache_pmem_resp  = 1'b0;
    bus.dcache_pmem_rdata = {LINE_W{1'b0}};
    bus.grant             = 2'b00;

    unique case (state_q)
      StIdle: begin
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
          state_d = (last_grant_q == GrantI) ? StDBusy : StIBusy;
        end else if (d_req) begin
          state_d = StDBusy;
        end else if (i_req) begin
          state_d = StIBusy;
        end
`else
        if (d_req) begin
          state_d = StDBusy;
        end else if (i_req) begin
          state_d = StIBusy;
        end
`endif
      end

      StIBusy: begin
        bus.pmem_read = 1'b1;
        bus.pmem_addr = bus.icache_pmem_addr;
        bus.grant     = 2'b01;
        if (bus.pmem_resp) begin
          bus.icache_pmem_resp  = 1'b1;
          bus.icache_pmem_rdata = bus.pmem_rdata;
          state_d               = StDone;
          last_grant_d          = GrantI;
        end
      end

      StDBusy: begin
        // Write takes precedence when a cache raises both strobes.
        bus.pmem_read  = bus.dcache_pmem_read & ~bus.dcache_pmem_write;
        bus.pmem_write = bus.dcache_pmem_write;
        bus.pmem_addr  = bus.dcache_pmem_addr;
        bus.pmem_wdata = bus.dcache_pmem_wdata;
        bus.grant      = 2'b10;
        if (bus.pmem_resp) begin
          bus.dcache_pmem_resp  = 1'b1;
          bus.dcache_pmem_rdata = bus.pmem_rdata;
          state_d               = StDone;
          last_grant_d          = GrantD;
        end
      end

      // One quiet cycle so the finished cache can drop its request before re-arbitration.
      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

endmodule
